cover_toggle_collector: RTL and testbench

COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

---
 rtl/cover_toggle_collector.sv | 113 +++++++++++
 tb/tb_cover_toggle_collector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cover_toggle_collector.sv
// Toggle-cover hit collector: sticky per-lane hit map plus a one-shot report
// stream of newly covered lanes, lowest lane first, with valid/ready output.
module cover_toggle_collector #(
  parameter int              LANES       = 8,
  parameter longint unsigned COVER_INDEX = 0,
  parameter int              INDEX_W     = 64,
  localparam int             CNT_W       = $clog2(LANES + 1),
  localparam int             LANE_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LANES-1:0]   valid,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INDEX_W-1:0] out_index,
  output logic [LANES-1:0]   hit_map,
  output logic [CNT_W-1:0]   hit_count,
  output logic               all_covered,
  output logic               fsm_hold
);

  // Output handshake: a report is transferred on a rising edge where
  // out_valid=1 and out_ready=1; while out_ready=0 out_index stays stable.

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  localparam logic [INDEX_W-1:0] BASE = INDEX_W'(COVER_INDEX);

  state_e             state_q;
  logic [LANES-1:0]   hit_map_q;
  logic [LANES-1:0]   hit_map_d;
  logic [LANES-1:0]   pending_q;
  logic [LANES-1:0]   pending_d;
  logic [INDEX_W-1:0] out_index_q;
  logic [INDEX_W-1:0] index_d;

  logic               sel_found;
  logic [LANE_W-1:0]  sel_lane;
  logic [LANES-1:0]   sel_onehot;
  logic [LANES-1:0]   new_hits;
  logic               advance;
  logic               load;
  logic [CNT_W-1:0]   count_c;

  // Descending scan so the last match written is the lowest pending lane.
  always_comb begin
    sel_found = 1'b0;
    sel_lane  = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_found = 1'b1;
        sel_lane  = LANE_W'(i);
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    if (sel_found) begin
      sel_onehot = LANES'(1) << sel_lane;
    end
    // A lane already in hit_map can never be re-armed, so a strobe landing
    // on the cycle its pending bit is consumed is naturally ignored.
    new_hits  = valid & ~hit_map_q & ~pending_q;
    advance   = (state_q == S_IDLE) || out_ready;
    load      = advance && sel_found;
    pending_d = (pending_q & ~(load ? sel_onehot : '0)) | new_hits;
    hit_map_d = hit_map_q | valid;
    index_d   = BASE + INDEX_W'(sel_lane);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hit_map_q   <= '0;
      pending_q   <= '0;
      out_index_q <= '0;
    end else if (clear) begin
      state_q     <= S_IDLE;
      hit_map_q   <= '0;
      pending_q   <= '0;
      out_index_q <= '0;
    end else begin
      hit_map_q <= hit_map_d;
      pending_q <= pending_d;
      if (load) begin
        state_q     <= S_HOLD;
        out_index_q <= index_d;
      end else if (advance) begin
        state_q <= S_IDLE;
      end
    end
  end

  always_comb begin
    count_c = '0;
    for (int i = 0; i < LANES; i++) begin
      count_c = count_c + CNT_W'(hit_map_q[i]);
    end
  end

  assign out_valid   = (state_q == S_HOLD);
  assign fsm_hold    = (state_q == S_HOLD);
  assign out_index   = out_index_q;
  assign hit_map     = hit_map_q;
  assign hit_count   = count_c;
  assign all_covered = &hit_map_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench for cover_toggle_collector: directed scenarios with literal
// expectations plus randomized traffic checked against a lane-set model.
module tb_cover_toggle_collector;

  localparam int LANES = 8;
  localparam int CI    = 100;
  localparam int IW    = 64;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    valid;
  logic          clear;
  logic          out_ready;
  logic          out_valid;
  logic [IW-1:0] out_index;
  logic [7:0]    hit_map;
  logic [CW-1:0] hit_count;
  logic          all_covered;
  logic          fsm_hold;

  int vectors     = 0;
  int miscompares = 0;

  logic [IW-1:0] acc_log[$];
  logic [IW-1:0] exp_q[$];

  // Model: set of covered lanes, set of lanes waiting to be reported, and
  // the report currently offered on the output.
  bit m_cov[LANES];
  bit m_q[LANES];
  bit m_valid;
  int m_lane;

  cover_toggle_collector #(
    .LANES(LANES), .COVER_INDEX(CI), .INDEX_W(IW)
  ) dut (
    .clock(clock), .reset(reset), .valid(valid), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .hit_map(hit_map), .hit_count(hit_count), .all_covered(all_covered),
    .fsm_hold(fsm_hold)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < LANES; i++) begin
      m_cov[i] = 1'b0;
      m_q[i]   = 1'b0;
    end
    m_valid = 1'b0;
    m_lane  = 0;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset || clear) begin
      m_reset();
    end else begin
      bit newh[LANES];
      for (int i = 0; i < LANES; i++) newh[i] = valid[i] && !m_cov[i];
      if (!m_valid || out_ready) begin
        m_valid = 1'b0;
        for (int i = 0; i < LANES; i++) begin
          if (m_q[i]) begin
            m_valid = 1'b1;
            m_lane  = i;
            m_q[i]  = 1'b0;
            break;
          end
        end
      end
      for (int i = 0; i < LANES; i++) begin
        if (newh[i]) begin
          m_q[i]   = 1'b1;
          m_cov[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [7:0] exp_map;
    int         exp_cnt;
    exp_map = '0;
    exp_cnt = 0;
    for (int i = 0; i < LANES; i++) begin
      exp_map[i] = m_cov[i];
      exp_cnt   += int'(m_cov[i]);
    end
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("fsm_hold", 64'(fsm_hold), 64'(m_valid));
    if (m_valid) check("out_index", out_index, 64'(CI + m_lane));
    check("hit_map", 64'(hit_map), 64'(exp_map));
    check("hit_count", 64'(hit_count), 64'(exp_cnt));
    check("all_covered", 64'(all_covered), 64'(exp_cnt == LANES));
    if (out_valid && out_ready && !clear && !reset) acc_log.push_back(out_index);
  end

  task automatic step(input logic [7:0] v, input logic rdy, input logic clr);
    valid     = v;
    out_ready = rdy;
    clear     = clr;
    @(posedge clock);
    #2;
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, 64'(acc_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
      check({name, "_idx"}, acc_log[i], exp_q[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    reset = 1'b1; valid = '0; clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_index", out_index, 64'd0);
    check("rst_hit_map", 64'(hit_map), 64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);

    // Single lane: two edges from strobe to report.
    step(8'h01, 1'b1, 1'b0);
    check("lat_e1_valid", 64'(out_valid), 64'd0);
    check("lat_e1_count", 64'(hit_count), 64'd1);
    step(8'h00, 1'b1, 1'b0);
    check("lat_e2_valid", 64'(out_valid), 64'd1);
    check("lat_e2_index", out_index, 64'd100);
    step(8'h00, 1'b1, 1'b0);
    check("lat_e3_valid", 64'(out_valid), 64'd0);

    // Burst of four lanes drains at one report per cycle.
    step(8'h00, 1'b1, 1'b1);
    step(8'hA5, 1'b1, 1'b0);
    check("burst_count", 64'(hit_count), 64'd4);
    check("burst_allcov", 64'(all_covered), 64'd0);
    for (int i = 0; i < 4; i++) begin
      logic [IW-1:0] want[4];
      want = '{100, 102, 105, 107};
      step(8'h00, 1'b1, 1'b0);
      check("burst_valid", 64'(out_valid), 64'd1);
      check("burst_index", out_index, want[i]);
    end
    step(8'h00, 1'b1, 1'b0);
    check("burst_done", 64'(out_valid), 64'd0);

    // Backpressure holds the offered index.
    step(8'h00, 1'b1, 1'b1);
    step(8'h06, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 1'b0, 1'b0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_index", out_index, 64'd101);
    end
    step(8'h00, 1'b1, 1'b0);
    check("bp_next_index", out_index, 64'd102);
    step(8'h00, 1'b1, 1'b0);
    check("bp_done", 64'(out_valid), 64'd0);

    // Repeated strobes report once; later full strobe reports the rest.
    step(8'h00, 1'b1, 1'b1);
    acc_log.delete();
    repeat (10) step(8'h01, 1'b1, 1'b0);
    repeat (3) step(8'h00, 1'b1, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    repeat (10) step(8'h00, 1'b1, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(100 + i));
    check_log("dedup");
    check("dedup_allcov", 64'(all_covered), 64'd1);

    // Clear discards strobes in the clear cycle and restarts the epoch.
    acc_log.delete();
    step(8'hFF, 1'b1, 1'b1);
    check("clr_hit_map", 64'(hit_map), 64'd0);
    check("clr_valid", 64'(out_valid), 64'd0);
    step(8'h80, 1'b1, 1'b0);
    repeat (4) step(8'h00, 1'b1, 1'b0);
    exp_q.delete();
    exp_q.push_back(64'd107);
    check_log("clear");
    check("clr_count", 64'(hit_count), 64'd1);

    // Reset while holding a report drops it.
    step(8'h00, 1'b1, 1'b1);
    step(8'h08, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("rh_valid", 64'(out_valid), 64'd1);
    check("rh_index", out_index, 64'd103);
    acc_log.delete();
    reset = 1'b1;
    #1;
    check("rh_async_valid", 64'(out_valid), 64'd0);
    check("rh_async_map", 64'(hit_map), 64'd0);
    check("rh_async_index", out_index, 64'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (4) step(8'h00, 1'b1, 1'b0);
    exp_q.delete();
    check_log("rst_hold");

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] v;
      v = '0;
      for (int b = 0; b < 8; b++) v[b] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
      end
      step(v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
    end
    step(8'h00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
